// File: rtl/keypad_scanner_if.sv
// Handshake bundle between the keypad scanner and gencon's key inputs.
// The scanner is the master: it presents digits, operators and equal requests.
// Gencon is the slave: it answers with key_read and complete.
interface keypad_scanner_if;
  logic [3:0] keypad_input;
  logic       read_input;
  logic       key_read;
  logic [2:0] operator_input;
  logic       equal_input;
  logic       complete;

  modport master (
    output keypad_input,
    output read_input,
    output operator_input,
    output equal_input,
    input  key_read,
    input  complete
  );

  modport slave (
    input  keypad_input,
    input  read_input,
    input  operator_input,
    input  equal_input,
    output key_read,
    output complete
  );
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad front end for gencon.
// Rotates a low row drive, synchronises and debounces the columns, and turns each
// accepted press into a digit handshake, a one-cycle operator pulse or an equal request.
// A press is issued exactly once; the key must be released cleanly before scanning resumes.
module keypad_scanner #(
  parameter int SCAN_DIV     = 1000,
  parameter int DEBOUNCE_CNT = 16
) (
  input  logic             clk,
  input  logic             nRST,
  output logic [3:0]       row_out,
  input  logic [3:0]       col_in,
  keypad_scanner_if.master gen
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DEB_W = $clog2(DEBOUNCE_CNT + 1);

  typedef enum logic [2:0] {
    S_SCAN,
    S_DEBOUNCE,
    S_ISSUE,
    S_WAIT_ACK,
    S_WAIT_CMP,
    S_RELEASE
  } state_t;

  state_t            state_q, state_d;
  logic [3:0]        col_meta_q, col_meta_d;
  logic [3:0]        col_sync_q, col_sync_d;
  logic [1:0]        row_idx_q, row_idx_d;
  logic [3:0]        row_out_q, row_out_d;
  logic [DIV_W-1:0]  dwell_cnt_q, dwell_cnt_d;
  logic [DEB_W-1:0]  deb_cnt_q, deb_cnt_d;
  logic [3:0]        cap_col_q, cap_col_d;
  logic [3:0]        keypad_input_q, keypad_input_d;
  logic              read_input_q, read_input_d;
  logic [2:0]        operator_input_q, operator_input_d;
  logic              equal_input_q, equal_input_d;

  logic              one_low;
  logic [1:0]        cap_idx;
  logic [DEB_W-1:0]  deb_next;

  // Classify the synchronised columns and locate the captured column.
  always_comb begin
    one_low = 1'b0;
    cap_idx = 2'd0;
    case (col_sync_q)
      4'b1110, 4'b1101, 4'b1011, 4'b0111: one_low = 1'b1;
      default:                            one_low = 1'b0;
    endcase
    case (cap_col_q)
      4'b1101: cap_idx = 2'd1;
      4'b1011: cap_idx = 2'd2;
      4'b0111: cap_idx = 2'd3;
      default: cap_idx = 2'd0;
    endcase
  end

  // Next-state logic: scan, debounce, issue, wait for gencon, then wait for release.
  always_comb begin
    state_d          = state_q;
    col_meta_d       = col_in;
    col_sync_d       = col_meta_q;
    row_idx_d        = row_idx_q;
    dwell_cnt_d      = dwell_cnt_q;
    deb_cnt_d        = deb_cnt_q;
    cap_col_d        = cap_col_q;
    keypad_input_d   = keypad_input_q;
    read_input_d     = read_input_q;
    operator_input_d = operator_input_q;
    equal_input_d    = equal_input_q;
    deb_next         = deb_cnt_q + DEB_W'(1);

    case (state_q)
      S_SCAN: begin
        if (dwell_cnt_q == DIV_W'(SCAN_DIV - 1)) begin
          dwell_cnt_d = '0;
          if (one_low) begin
            state_d   = S_DEBOUNCE;
            cap_col_d = col_sync_q;
            deb_cnt_d = '0;
          end else begin
            row_idx_d = row_idx_q + 2'd1;
          end
        end else begin
          dwell_cnt_d = dwell_cnt_q + DIV_W'(1);
        end
      end

      S_DEBOUNCE: begin
        if (col_sync_q != cap_col_q) begin
          state_d     = S_SCAN;
          dwell_cnt_d = '0;
          deb_cnt_d   = '0;
        end else if (deb_next == DEB_W'(DEBOUNCE_CNT)) begin
          state_d   = S_ISSUE;
          deb_cnt_d = '0;
          case ({row_idx_q, cap_idx})
            4'h0: begin keypad_input_d = 4'd1; read_input_d = 1'b1; end
            4'h1: begin keypad_input_d = 4'd2; read_input_d = 1'b1; end
            4'h2: begin keypad_input_d = 4'd3; read_input_d = 1'b1; end
            4'h3: operator_input_d = 3'b010;
            4'h4: begin keypad_input_d = 4'd4; read_input_d = 1'b1; end
            4'h5: begin keypad_input_d = 4'd5; read_input_d = 1'b1; end
            4'h6: begin keypad_input_d = 4'd6; read_input_d = 1'b1; end
            4'h7: operator_input_d = 3'b011;
            4'h8: begin keypad_input_d = 4'd7; read_input_d = 1'b1; end
            4'h9: begin keypad_input_d = 4'd8; read_input_d = 1'b1; end
            4'hA: begin keypad_input_d = 4'd9; read_input_d = 1'b1; end
            4'hB: operator_input_d = 3'b100;
            4'hC: equal_input_d = 1'b1;
            4'hD: begin keypad_input_d = 4'd0; read_input_d = 1'b1; end
            4'hF: operator_input_d = 3'b001;
            default: ;
          endcase
        end else begin
          deb_cnt_d = deb_next;
        end
      end

      S_ISSUE: begin
        operator_input_d = 3'b000;
        if (read_input_q) begin
          state_d = S_WAIT_ACK;
        end else if (equal_input_q) begin
          state_d = S_WAIT_CMP;
        end else begin
          state_d = S_RELEASE;
        end
      end

      S_WAIT_ACK: begin
        if (gen.key_read) begin
          keypad_input_d = 4'd0;
          read_input_d   = 1'b0;
          state_d        = S_RELEASE;
        end
      end

      S_WAIT_CMP: begin
        if (gen.complete) begin
          equal_input_d = 1'b0;
          state_d       = S_RELEASE;
        end
      end

      S_RELEASE: begin
        if (col_sync_q == 4'hF) begin
          if (deb_next == DEB_W'(DEBOUNCE_CNT)) begin
            state_d     = S_SCAN;
            deb_cnt_d   = '0;
            dwell_cnt_d = '0;
            row_idx_d   = row_idx_q + 2'd1;
          end else begin
            deb_cnt_d = deb_next;
          end
        end else begin
          deb_cnt_d = '0;
        end
      end

      default: state_d = S_SCAN;
    endcase

    row_out_d = ~(4'b0001 << row_idx_d);
  end

  // State and output registers; reset returns everything to idle scanning of row 0.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state_q          <= S_SCAN;
      col_meta_q       <= 4'hF;
      col_sync_q       <= 4'hF;
      row_idx_q        <= 2'd0;
      row_out_q        <= 4'b1110;
      dwell_cnt_q      <= '0;
      deb_cnt_q        <= '0;
      cap_col_q        <= 4'hF;
      keypad_input_q   <= 4'd0;
      read_input_q     <= 1'b0;
      operator_input_q <= 3'b000;
      equal_input_q    <= 1'b0;
    end else begin
      state_q          <= state_d;
      col_meta_q       <= col_meta_d;
      col_sync_q       <= col_sync_d;
      row_idx_q        <= row_idx_d;
      row_out_q        <= row_out_d;
      dwell_cnt_q      <= dwell_cnt_d;
      deb_cnt_q        <= deb_cnt_d;
      cap_col_q        <= cap_col_d;
      keypad_input_q   <= keypad_input_d;
      read_input_q     <= read_input_d;
      operator_input_q <= operator_input_d;
      equal_input_q    <= equal_input_d;
    end
  end

  assign row_out            = row_out_q;
  assign gen.keypad_input   = keypad_input_q;
  assign gen.read_input     = read_input_q;
  assign gen.operator_input = operator_input_q;
  assign gen.equal_input    = equal_input_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Testbench for keypad_scanner with a behavioural 4x4 key matrix and a
// scoreboard of expected issues (100+digit, 200+operator code, 300 for equal).
module tb_keypad_scanner;

  logic        clk;
  logic        nRST;
  logic [3:0]  row_out;
  logic [3:0]  col_in;
  logic [15:0] pressed;

  int errors;
  int checks;
  int exp_q[$];

  keypad_scanner_if kif();

  keypad_scanner #(.SCAN_DIV(8), .DEBOUNCE_CNT(4)) dut (
    .clk     (clk),
    .nRST    (nRST),
    .row_out (row_out),
    .col_in  (col_in),
    .gen     (kif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Key matrix: a pressed key pulls its column low while its row is driven low.
  always_comb begin
    col_in = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (pressed[r*4+c] && !row_out[r]) col_in[c] = 1'b0;
      end
    end
  end

  // Output monitor: turns DUT issues into events and matches them against the scoreboard.
  initial begin
    logic       prev_read;
    logic [3:0] prev_keypad;
    logic [2:0] prev_op;
    logic       prev_eq;
    int         got;
    int         want;
    prev_read   = 1'b0;
    prev_keypad = 4'd0;
    prev_op     = 3'b000;
    prev_eq     = 1'b0;
    forever begin
      @(negedge clk);
      if (nRST) begin
        checks++;
        if ((kif.read_input && kif.operator_input != 3'b000) ||
            (kif.read_input && kif.equal_input) ||
            (kif.equal_input && kif.operator_input != 3'b000)) begin
          errors++;
          $display("[TB] FAIL exclusive_outputs: read=%0b op=%03b eq=%0b, required at most one active",
                   kif.read_input, kif.operator_input, kif.equal_input);
        end
        if (kif.read_input && prev_read) begin
          checks++;
          if (kif.keypad_input !== prev_keypad) begin
            errors++;
            $display("[TB] FAIL digit_stable: keypad_input=%0d, required %0d", kif.keypad_input, prev_keypad);
          end
        end
        if (kif.operator_input != 3'b000) begin
          checks++;
          if (prev_op !== 3'b000) begin
            errors++;
            $display("[TB] FAIL op_width: operator_input=%03b held after %03b, required single cycle",
                     kif.operator_input, prev_op);
          end
        end
        got = -1;
        if (kif.read_input && !prev_read) got = 100 + int'(kif.keypad_input);
        if (kif.operator_input != 3'b000 && prev_op == 3'b000) got = 200 + int'(kif.operator_input);
        if (kif.equal_input && !prev_eq) got = 300;
        if (got >= 0) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("[TB] FAIL unexpected_issue: got event %0d, required none", got);
          end else begin
            want = exp_q.pop_front();
            if (got != want) begin
              errors++;
              $display("[TB] FAIL issue_value: got event %0d, required %0d", got, want);
            end
          end
        end
      end
      prev_read   = kif.read_input;
      prev_keypad = kif.keypad_input;
      prev_op     = kif.operator_input;
      prev_eq     = kif.equal_input;
    end
  end

  task automatic press(input int r, input int c);
    pressed[r*4+c] = 1'b1;
  endtask

  task automatic release_keys();
    pressed = 16'h0000;
    repeat (30) @(negedge clk);
  endtask

  // kind 1: read_input, 2: any operator, 3: equal_input
  task automatic wait_output(input int kind, input int budget, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (kind == 1 && kif.read_input) seen = 1'b1;
      if (kind == 2 && kif.operator_input != 3'b000) seen = 1'b1;
      if (kind == 3 && kif.equal_input) seen = 1'b1;
    end
  endtask

  task automatic test_reset();
    logic [3:0] exp_row;
    nRST = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (row_out !== 4'b1110 || kif.read_input !== 1'b0 || kif.keypad_input !== 4'd0 ||
        kif.operator_input !== 3'b000 || kif.equal_input !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_values: row=%04b read=%0b key=%0d op=%03b eq=%0b, required 1110 0 0 000 0",
               row_out, kif.read_input, kif.keypad_input, kif.operator_input, kif.equal_input);
    end
    nRST = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if (row_out !== 4'b1110) begin
      errors++;
      $display("[TB] FAIL row_dwell: row_out=%04b, required 1110", row_out);
    end
    repeat (4) @(negedge clk);
    for (int k = 1; k <= 4; k++) begin
      exp_row = ~(4'b0001 << (k % 4));
      checks++;
      if (row_out !== exp_row) begin
        errors++;
        $display("[TB] FAIL row_rotate_%0d: row_out=%04b, required %04b", k, row_out, exp_row);
      end
      repeat (8) @(negedge clk);
    end
  endtask

  task automatic test_digit_hold();
    bit seen;
    exp_q.push_back(107);
    press(2, 0);
    wait_output(1, 100, seen);
    checks++;
    if (!seen) begin
      errors++;
      $display("[TB] FAIL digit7_timeout: read_input=0, required 1 within 100 cycles");
    end else begin
      checks++;
      if (kif.keypad_input !== 4'd7) begin
        errors++;
        $display("[TB] FAIL digit7_value: keypad_input=%0d, required 7", kif.keypad_input);
      end
      repeat (2) @(negedge clk);
      kif.complete = 1'b1;
      @(negedge clk);
      kif.complete = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if (kif.read_input !== 1'b1 || kif.keypad_input !== 4'd7) begin
        errors++;
        $display("[TB] FAIL digit7_held: read=%0b key=%0d, required 1 7", kif.read_input, kif.keypad_input);
      end
      kif.key_read = 1'b1;
      @(negedge clk);
      kif.key_read = 1'b0;
      checks++;
      if (kif.read_input !== 1'b0 || kif.keypad_input !== 4'd0) begin
        errors++;
        $display("[TB] FAIL digit7_ack: read=%0b key=%0d, required 0 0", kif.read_input, kif.keypad_input);
      end
    end
    repeat (180) @(negedge clk);
    release_keys();
  endtask

  task automatic test_bounce();
    bit seen;
    for (int i = 0; i < 20; i++) begin
      pressed[5] = ~pressed[5];
      repeat (2) @(negedge clk);
    end
    exp_q.push_back(105);
    press(1, 1);
    wait_output(1, 100, seen);
    checks++;
    if (!seen || kif.keypad_input !== 4'd5) begin
      errors++;
      $display("[TB] FAIL bounce_digit5: seen=%0b key=%0d, required 1 5", seen, kif.keypad_input);
    end
    repeat (3) @(negedge clk);
    kif.key_read = 1'b1;
    @(negedge clk);
    kif.key_read = 1'b0;
    repeat (40) @(negedge clk);
    release_keys();
  endtask

  task automatic test_operators();
    bit seen;
    int code[4];
    code = '{2, 3, 4, 1};
    for (int k = 0; k < 4; k++) begin
      exp_q.push_back(200 + code[k]);
      press(k, 3);
      wait_output(2, 100, seen);
      checks++;
      if (!seen || int'(kif.operator_input) != code[k]) begin
        errors++;
        $display("[TB] FAIL op_row%0d: operator_input=%03b, required %0d", k, kif.operator_input, code[k]);
      end
      @(negedge clk);
      checks++;
      if (kif.operator_input !== 3'b000) begin
        errors++;
        $display("[TB] FAIL op_row%0d_clear: operator_input=%03b, required 000", k, kif.operator_input);
      end
      repeat (20) @(negedge clk);
      release_keys();
    end
  endtask

  task automatic test_equal();
    bit seen;
    exp_q.push_back(300);
    press(3, 0);
    wait_output(3, 100, seen);
    checks++;
    if (!seen) begin
      errors++;
      $display("[TB] FAIL equal_timeout: equal_input=0, required 1 within 100 cycles");
    end
    repeat (30) @(negedge clk);
    checks++;
    if (kif.equal_input !== 1'b1) begin
      errors++;
      $display("[TB] FAIL equal_held: equal_input=%0b, required 1", kif.equal_input);
    end
    kif.key_read = 1'b1;
    @(negedge clk);
    kif.key_read = 1'b0;
    checks++;
    if (kif.equal_input !== 1'b1) begin
      errors++;
      $display("[TB] FAIL equal_keyread_ignored: equal_input=%0b, required 1", kif.equal_input);
    end
    kif.key_read = 1'b1;
    kif.complete = 1'b1;
    @(negedge clk);
    kif.key_read = 1'b0;
    kif.complete = 1'b0;
    checks++;
    if (kif.equal_input !== 1'b0 || kif.read_input !== 1'b0) begin
      errors++;
      $display("[TB] FAIL equal_complete: eq=%0b read=%0b, required 0 0", kif.equal_input, kif.read_input);
    end
    repeat (40) @(negedge clk);
    release_keys();
  endtask

  task automatic test_no_key();
    logic [3:0] rows_seen;
    bit         frozen;
    press(0, 0);
    press(0, 2);
    repeat (100) @(negedge clk);
    rows_seen = 4'h0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      rows_seen = rows_seen | ~row_out;
    end
    checks++;
    if (rows_seen !== 4'hF) begin
      errors++;
      $display("[TB] FAIL double_press_scan: rows seen=%04b, required 1111", rows_seen);
    end
    release_keys();
    press(3, 2);
    repeat (60) @(negedge clk);
    frozen = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (row_out !== 4'b0111) frozen = 1'b0;
    end
    checks++;
    if (!frozen) begin
      errors++;
      $display("[TB] FAIL hash_consumed: row_out=%04b, required held at 0111", row_out);
    end
    release_keys();
    rows_seen = 4'h0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      rows_seen = rows_seen | ~row_out;
    end
    checks++;
    if (rows_seen !== 4'hF) begin
      errors++;
      $display("[TB] FAIL hash_rescan: rows seen=%04b, required 1111", rows_seen);
    end
  endtask

  task automatic test_reset_mid();
    bit seen;
    exp_q.push_back(109);
    press(2, 2);
    wait_output(1, 100, seen);
    checks++;
    if (!seen || kif.keypad_input !== 4'd9) begin
      errors++;
      $display("[TB] FAIL digit9_first: seen=%0b key=%0d, required 1 9", seen, kif.keypad_input);
    end
    repeat (2) @(negedge clk);
    #1;
    nRST = 1'b0;
    #1;
    checks++;
    if (kif.read_input !== 1'b0 || kif.keypad_input !== 4'd0 || row_out !== 4'b1110) begin
      errors++;
      $display("[TB] FAIL async_reset: read=%0b key=%0d row=%04b, required 0 0 1110",
               kif.read_input, kif.keypad_input, row_out);
    end
    exp_q.push_back(109);
    repeat (2) @(negedge clk);
    nRST = 1'b1;
    wait_output(1, 100, seen);
    checks++;
    if (!seen || kif.keypad_input !== 4'd9) begin
      errors++;
      $display("[TB] FAIL digit9_reissue: seen=%0b key=%0d, required 1 9", seen, kif.keypad_input);
    end
    repeat (3) @(negedge clk);
    kif.key_read = 1'b1;
    @(negedge clk);
    kif.key_read = 1'b0;
    release_keys();
  endtask

  initial begin
    errors       = 0;
    checks       = 0;
    pressed      = 16'h0000;
    nRST         = 1'b0;
    kif.key_read = 1'b0;
    kif.complete = 1'b0;
    test_reset();
    test_digit_hold();
    test_bounce();
    test_operators();
    test_equal();
    test_no_key();
    test_reset_mid();
    repeat (10) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain: %0d issues outstanding, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
